update_packer: RTL

UPDATE_PACKER -- requirements
Module: update_packer

---
 rtl/update_packer_pkg.sv | 15 +
 rtl/update_packer_merge.sv | 45 ++++
 rtl/update_packer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/update_packer_pkg.sv
// rtl/update_packer_pkg.sv - shared sort/packer constants and state encoding
// Lane geometry, slot-count width and packer state encoding.
package update_packer_pkg;

    localparam int LANES  = 8;
    localparam int WORD_W = 32;
    // Wide enough for a merged total of 0..15 words.
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/update_packer_merge.sv
// rtl/update_packer_merge.sv - residue + new-lane merge network (combinational)
// Ports:
//   residue_i    : up to LANES-1 buffered words, slot 0 oldest
//   res_cnt_i    : number of valid residue words (0..LANES-1)
//   lanes_i      : sorted lane payloads, lane 0 in the low bits
//   lane_valid_i : per-lane valid, set lanes contiguous at the top
//   beat_valid_i : beat qualifier
//   merged_o     : residue followed by new words, zero beyond total_o
//   total_o      : residue count plus new word count
module packer_merge
    import update_packer_pkg::*;
#(
    parameter int LANES  = update_packer_pkg::LANES,
    parameter int WORD_W = update_packer_pkg::WORD_W
) (
    input  logic [(LANES-1)*WORD_W-1:0]   residue_i,
    input  logic [CNT_W-1:0]              res_cnt_i,
    input  logic [LANES*WORD_W-1:0]       lanes_i,
    input  logic [LANES-1:0]              lane_valid_i,
    input  logic                          beat_valid_i,
    output logic [(2*LANES-1)*WORD_W-1:0] merged_o,
    output logic [CNT_W-1:0]              total_o
);

    logic [CNT_W-1:0] new_cnt;

    always_comb begin
        merged_o = '0;
        // Only the count matters: the sort stage packs valid lanes at the top.
        new_cnt  = beat_valid_i ? CNT_W'($countones(lane_valid_i)) : '0;
        for (int j = 0; j < LANES - 1; j++) begin
            if (j < int'(res_cnt_i)) begin
                merged_o[j*WORD_W +: WORD_W] = residue_i[j*WORD_W +: WORD_W];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(new_cnt)) begin
                merged_o[(int'(res_cnt_i) + i)*WORD_W +: WORD_W] =
                    lanes_i[(LANES - int'(new_cnt) + i)*WORD_W +: WORD_W];
            end
        end
        total_o = res_cnt_i + new_cnt;
    end

endmodule

// File: rtl/update_packer.sv
// rtl/update_packer.sv - packs sorted lane words into full 8-word lines
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   word_in0..7, valid_in0..7    : sorted lane payloads and per-lane valids
//   word_in_valid, last_input_in : beat qualifier, end-of-stream marker
//   control_in                   : sideband captured with the completing beat
//   word_out0..7, line_valid     : packed line (slot 0 oldest), one-cycle strobe
//   line_count, line_last        : occupied slots, final line of the stream
//   control_out, overflow_err    : sideband of the line, sticky input-in-FLUSH flag
module update_packer
    import update_packer_pkg::*;
#(
    parameter int LANES  = update_packer_pkg::LANES,
    parameter int WORD_W = update_packer_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in0, word_in1, word_in2, word_in3,
    input  logic [WORD_W-1:0] word_in4, word_in5, word_in6, word_in7,
    input  logic              valid_in0, valid_in1, valid_in2, valid_in3,
    input  logic              valid_in4, valid_in5, valid_in6, valid_in7,
    input  logic              word_in_valid,
    input  logic              last_input_in,
    input  logic [1:0]        control_in,
    output logic [WORD_W-1:0] word_out0, word_out1, word_out2, word_out3,
    output logic [WORD_W-1:0] word_out4, word_out5, word_out6, word_out7,
    output logic              line_valid,
    output logic [CNT_W-1:0]  line_count,
    output logic              line_last,
    output logic [1:0]        control_out,
    output logic              overflow_err
);

    localparam int RES_N = LANES - 1;
    localparam int MRG_N = 2*LANES - 1;

    logic [LANES*WORD_W-1:0] lanes;
    logic [LANES-1:0]        lane_valid;
    logic [MRG_N*WORD_W-1:0] merged;
    logic [CNT_W-1:0]        total;

    state_e                  state_q, state_d;
    logic [RES_N*WORD_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]        r_q, r_d;
    logic [LANES*WORD_W-1:0] words_q, words_d;
    logic                    lv_q, lv_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic                    ovf_q, ovf_d;

    assign lanes      = {word_in7, word_in6, word_in5, word_in4,
                         word_in3, word_in2, word_in1, word_in0};
    assign lane_valid = {valid_in7, valid_in6, valid_in5, valid_in4,
                         valid_in3, valid_in2, valid_in1, valid_in0};

    packer_merge #(
        .LANES  (LANES),
        .WORD_W (WORD_W)
    ) u_merge (
        .residue_i    (res_q),
        .res_cnt_i    (r_q),
        .lanes_i      (lanes),
        .lane_valid_i (lane_valid),
        .beat_valid_i (word_in_valid),
        .merged_o     (merged),
        .total_o      (total)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        r_d     = r_q;
        words_d = words_q;
        lv_d    = 1'b0;
        last_d  = 1'b0;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                if (last_input_in) begin
                    lv_d    = 1'b1;
                    ctrl_d  = control_in;
                    // merged is zero beyond total, so short lines come out zero-padded.
                    words_d = merged[LANES*WORD_W-1:0];
                    if (total <= CNT_W'(LANES)) begin
                        last_d = 1'b1;
                        cnt_d  = total;
                        res_d  = '0;
                        r_d    = '0;
                    end else begin
                        // Overflow words wait in the residue for the FLUSH line.
                        cnt_d   = CNT_W'(LANES);
                        res_d   = merged[MRG_N*WORD_W-1:LANES*WORD_W];
                        r_d     = total - CNT_W'(LANES);
                        state_d = ST_FLUSH;
                    end
                end else if (total >= CNT_W'(LANES)) begin
                    lv_d    = 1'b1;
                    ctrl_d  = control_in;
                    words_d = merged[LANES*WORD_W-1:0];
                    cnt_d   = CNT_W'(LANES);
                    res_d   = merged[MRG_N*WORD_W-1:LANES*WORD_W];
                    r_d     = total - CNT_W'(LANES);
                end else begin
                    res_d = merged[RES_N*WORD_W-1:0];
                    r_d   = total;
                end
            end
            ST_FLUSH: begin
                // control_out keeps the value of the last beat that caused the flush.
                lv_d    = 1'b1;
                last_d  = 1'b1;
                cnt_d   = r_q;
                words_d = {{WORD_W{1'b0}}, res_q};
                res_d   = '0;
                r_d     = '0;
                state_d = ST_RUN;
                if (word_in_valid || last_input_in) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            res_q   <= '0;
            r_q     <= '0;
            words_q <= '0;
            lv_q    <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            r_q     <= r_d;
            words_q <= words_d;
            lv_q    <= lv_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_out0    = words_q[0*WORD_W +: WORD_W];
    assign word_out1    = words_q[1*WORD_W +: WORD_W];
    assign word_out2    = words_q[2*WORD_W +: WORD_W];
    assign word_out3    = words_q[3*WORD_W +: WORD_W];
    assign word_out4    = words_q[4*WORD_W +: WORD_W];
    assign word_out5    = words_q[5*WORD_W +: WORD_W];
    assign word_out6    = words_q[6*WORD_W +: WORD_W];
    assign word_out7    = words_q[7*WORD_W +: WORD_W];
    assign line_valid   = lv_q;
    assign line_count   = cnt_q;
    assign line_last    = last_q;
    assign control_out  = ctrl_q;
    assign overflow_err = ovf_q;

endmodule
